// File: rtl/ds1302_slave.sv
// DS1302-compatible responder on the CE/SCLK/IO link, serving the 8 clock/control registers.
// Optional `DS1302_BURST_EN enables clock burst (addr 31); otherwise addr 31 is rejected.
module ds1302_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       ds1302_ce,
  input  logic       ds1302_sclk,
  input  logic       io_in,
  output logic       io_out,
  output logic       io_oe,
  output logic [7:0] rtc_second,
  output logic [7:0] rtc_minute,
  output logic [7:0] rtc_hour,
  output logic [7:0] rtc_date,
  output logic [7:0] rtc_month,
  output logic [7:0] rtc_week,
  output logic [7:0] rtc_year,
  output logic [7:0] rtc_ctrl,
  output logic       wr_strobe,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ce_sync_q, sclk_sync_q, io_sync_q;
  logic                   ce_prev_q, sclk_prev_q;
  logic [7:0]             regs_q [8];
  logic [7:0]             regs_d [8];
  logic [7:0]             shift_q, shift_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             addr_q, addr_d;
  logic [7:0]             rd_byte_q, rd_byte_d;
  logic                   io_out_q, io_out_d;
  logic                   io_oe_q, io_oe_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic                   busy_q, busy_d;

  logic       ce_s, sclk_s, io_s, ce_rise_s, sclk_rise_s, sclk_fall_s;
  logic [7:0] byte_in_s, next_byte_s;
  logic [4:0] cmd_addr_s;
  logic [2:0] start_addr_s, next_addr_s;
  logic       is_burst_s, cmd_valid_s, burst_s;

  assign ce_s        = ce_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign io_s        = io_sync_q[SYNC_STAGES-1];
  assign ce_rise_s   = ce_s & ~ce_prev_q;
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign byte_in_s   = {io_s, shift_q[7:1]};
  assign cmd_addr_s  = byte_in_s[5:1];
  assign next_addr_s = addr_q + 3'd1;
  assign next_byte_s = regs_q[next_addr_s];

`ifdef DS1302_BURST_EN
  logic burst_q, burst_d;
  assign is_burst_s = (cmd_addr_s == 5'd31);
  assign burst_s    = burst_q;
`else
  assign is_burst_s = 1'b0;
  assign burst_s    = 1'b0;
`endif

  assign cmd_valid_s  = byte_in_s[7] & ~byte_in_s[6] & ((cmd_addr_s < 5'd8) | is_burst_s);
  assign start_addr_s = is_burst_s ? 3'd0 : cmd_addr_s[2:0];

  // Next-state logic: command decode, write shift/commit, read serialisation.
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rd_byte_d   = rd_byte_q;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;
    wr_strobe_d = 1'b0;
`ifdef DS1302_BURST_EN
    burst_d     = burst_q;
`endif
    if (!ce_s) begin
      state_d = S_IDLE;
      io_oe_d = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ce_rise_s) begin
            state_d = S_CMD;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          if (sclk_rise_s) begin
            shift_d = byte_in_s;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d     = 4'd0;
              addr_d    = start_addr_s;
              rd_byte_d = regs_q[start_addr_s];
`ifdef DS1302_BURST_EN
              burst_d   = is_burst_s;
`endif
              if (!cmd_valid_s) begin
                state_d = S_DONE;
              end else if (byte_in_s[0]) begin
                state_d = S_RDATA;
              end else begin
                state_d = S_WDATA;
              end
            end else begin
              state_d = S_CMD;
            end
          end else begin
            state_d = S_CMD;
          end
        end
        S_WDATA: begin
          if (sclk_rise_s) begin
            shift_d = byte_in_s;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              // The control register stays writable so WP can always be cleared.
              if ((addr_q == 3'd7) || !regs_q[7][7]) begin
                regs_d[addr_q] = byte_in_s;
                wr_strobe_d    = 1'b1;
              end else begin
                wr_strobe_d = 1'b0;
              end
              if (burst_s && (addr_q != 3'd7)) begin
                addr_d = next_addr_s;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              state_d = S_WDATA;
            end
          end else begin
            state_d = S_WDATA;
          end
        end
        S_RDATA: begin
          if (sclk_fall_s) begin
            if (cnt_q < 4'd8) begin
              io_out_d = rd_byte_q[cnt_q[2:0]];
              io_oe_d  = 1'b1;
              cnt_d    = cnt_q + 4'd1;
            end else if (burst_s && (addr_q != 3'd7)) begin
              addr_d    = next_addr_s;
              rd_byte_d = next_byte_s;
              io_out_d  = next_byte_s[0];
              io_oe_d   = 1'b1;
              cnt_d     = 4'd1;
            end else begin
              io_oe_d = 1'b0;
              state_d = S_DONE;
            end
          end else begin
            state_d = S_RDATA;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State, register file, synchronizers and registered outputs.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      // CE chain resets high so a frame already in progress is not mistaken for a new one.
      ce_sync_q   <= {SYNC_STAGES{1'b1}};
      ce_prev_q   <= 1'b1;
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      io_sync_q   <= {SYNC_STAGES{1'b0}};
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
      shift_q     <= 8'h00;
      cnt_q       <= 4'd0;
      addr_q      <= 3'd0;
      rd_byte_q   <= 8'h00;
      io_out_q    <= 1'b0;
      io_oe_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DS1302_BURST_EN
      burst_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], ds1302_ce};
      ce_prev_q   <= ce_s;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ds1302_sclk};
      sclk_prev_q <= sclk_s;
      io_sync_q   <= {io_sync_q[SYNC_STAGES-2:0], io_in};
      regs_q      <= regs_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rd_byte_q   <= rd_byte_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      wr_strobe_q <= wr_strobe_d;
      busy_q      <= busy_d;
`ifdef DS1302_BURST_EN
      burst_q     <= burst_d;
`endif
    end
  end

  assign io_out     = io_out_q;
  assign io_oe      = io_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign busy       = busy_q;
  assign rtc_second = regs_q[0];
  assign rtc_minute = regs_q[1];
  assign rtc_hour   = regs_q[2];
  assign rtc_date   = regs_q[3];
  assign rtc_month  = regs_q[4];
  assign rtc_week   = regs_q[5];
  assign rtc_year   = regs_q[6];
  assign rtc_ctrl   = regs_q[7];

endmodule

// File: doc/ds1302_slave.md
# ds1302_slave

Synthesizable DS1302-compatible responder: the device end of the 3-wire CE/SCLK/IO link driven by our `ds1302` controller. Oversamples CE/SCLK on `sysclk`, decodes command bytes, and serves reads/writes of the 8 clock/control registers, including clock burst. Used as the on-FPGA stand-in for the RTC chip in loopback benches and board-less bring-up. No timekeeping; registers change only through link writes.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `ds1302_ce`/`ds1302_sclk`/`io_in` (≥2).

Ports:
- `sysclk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `ds1302_ce`  in  1  chip enable from controller
- `ds1302_sclk`  in  1  serial clock from controller
- `io_in`  in  1  IO pad input
- `io_out`  out  1  IO pad output value
- `io_oe`  out  1  IO output enable (top level tri-states pad)
- `rtc_second`, `rtc_minute`, `rtc_hour`, `rtc_date`, `rtc_month`, `rtc_week`, `rtc_year`  out  8 each  register contents (addr 0..6)
- `rtc_ctrl`  out  8  control register (addr 7); bit7 = WP
- `wr_strobe`  out  1  one-cycle pulse per committed register write
- `busy`  out  1  high while FSM not IDLE

## Operation
- Inputs pass `SYNC_STAGES` flops; edge detect on synchronized SCLK gives `sclk_rise`/`sclk_fall`.
- Frame: synchronized CE high; command byte LSB first, sampled on 8 SCLK rising edges. Cmd bit7 must be 1; bit6 = RAM/CK; bits5:1 = addr; bit0 = 1 read / 0 write.
- FSM states: IDLE, CMD, WDATA, RDATA, DONE.
  - IDLE → CMD on CE high; bit counter cleared.
  - CMD → after 8th rise: bit7=0, bit6=1, or addr 8..30 → DONE (ignored, `io_oe` stays 0); read → RDATA; write → WDATA. Addr 31 = clock burst (byte index starts at 0).
  - WDATA: shift 8 bits on rises; on 8th, commit to addr (burst: index), pulse `wr_strobe`. Burst continues to next index; after index 7 or single write → DONE.
  - RDATA: on each fall drive next bit LSB first on `io_out`, `io_oe`=1; first bit on the fall following the 8th command rise. After the 8th bit's fall... on the next fall: burst advances index and drives bit0 of next byte; single or index 7 done → `io_oe`=0, DONE.
  - DONE: ignore SCLK until CE low.
  - Any state: synchronized CE low → IDLE, `io_oe`=0, partial byte discarded.
- Write protect: if `rtc_ctrl[7]`=1, writes to addr 0..6 are dropped (no `wr_strobe`); writes to addr 7 always accepted. In burst, WP evaluated per byte with the value current at commit.
- Read data latched at byte start; a concurrent commit does not alter a byte in flight.

## Timing
- Reset: all `rtc_*` = 0x00, `io_out`=0, `io_oe`=0, `wr_strobe`=0, `busy`=0, FSM IDLE.
- Edge-to-action latency: `SYNC_STAGES`+1 `sysclk` cycles from raw SCLK/CE transition.
- Requirement on driver: SCLK high and low each ≥ `SYNC_STAGES`+2 `sysclk` cycles; CE setup to first rise ≥ same.
- Register update and `wr_strobe` occur in the same cycle as the 8th data-bit rise detect.
- `rst` asserted mid-frame: immediate return to reset values; frame resumes only after CE low→high.

## Configuration
- `DS1302_BURST_EN` defined: addr 31 clock burst supported as above.
- Undefined: addr 31 treated as invalid → DONE; burst logic (byte index) removed.

## Test plan
- Reset → all `rtc_*`=0x00, `io_oe`=0, `busy`=0.
- Write cmd 0x80, data 0x01 → `rtc_second`=0x01, one `wr_strobe`; then read cmd 0x81 → `io_out` bits 1,0,0,0,0,0,0,0 on successive falls, `io_oe` drops after 8th.
- Burst write 0xBE with 0x01..0x07, 0x00 (with `DS1302_BURST_EN`) → registers 0x01..0x07, ctrl 0x00, 8 strobes; burst read 0xBF returns same 64 bits.
- Write ctrl 0x8E/0x80, then 0x82/0x55 → `rtc_minute` unchanged, no strobe; write 0x8E/0x00 then 0x82/0x55 → `rtc_minute`=0x55.
- CE low after 5 data bits of 0x84/0x12 → `rtc_hour` unchanged, FSM IDLE; next full frame works.
- `rst` low during RDATA → `io_oe`=0 immediately; invalid cmd 0x40 → no drive, no strobe.
